cache_ctrl_nway: RTL and testbench

// Parametrised write-back, write-allocate cache controller for an N-way set-associative cache.

---
 rtl/cache_ctrl_pkg.sv | 27 ++
 rtl/victim_sel.sv | 44 ++++
 rtl/cache_ctrl_nway.sv | 187 ++++++++++++++++++
 tb/tb_cache_ctrl_nway.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared state encodings and width helpers for the n-way cache controller
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVICT = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int WORD_BITS = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Byte offset within a line of 16-bit words: word index plus the byte bit.
  function automatic int off_width(input int line_words);
    return clog2(line_words) + 1;
  endfunction

endpackage

// File: rtl/victim_sel.sv
// rtl/victim_sel.sv - victim picker: lowest invalid way, else round-robin pointer
module victim_sel
  import cache_ctrl_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WAYS-1:0] valid_i,
  input  logic            advance_i,
  output logic [WAYS-1:0] victim_o,
  output logic            all_valid_o
);

  localparam int PW = clog2(WAYS);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  always_comb begin
    victim_o    = '0;
    found       = 1'b0;
    all_valid_o = &valid_i;
    for (int i = 0; i < WAYS; i++) begin
      if (!valid_i[i] && !found) begin
        victim_o[i] = 1'b1;
        found       = 1'b1;
      end
    end
    if (all_valid_o) victim_o = WAYS'(1) << ptr_q;
  end

  // WAYS is a power of two, so natural wrap of the pointer is the modulo.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cache_ctrl_nway.sv
// rtl/cache_ctrl_nway.sv - write-back, write-allocate controller for an N-way set-associative cache
module cache_ctrl_nway
  import cache_ctrl_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT    = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [15:0]                         addr_in,
  input  logic [15:0]                         data_in,
  input  logic                                rd_in,
  input  logic                                wr_in,
  input  logic [WAYS-1:0]                     cache_hit,
  input  logic [WAYS-1:0]                     cache_valid,
  input  logic [WAYS-1:0]                     cache_dirty,
  output logic [15:0]                         addr_out,
  output logic [15:0]                         data_out,
  output logic [off_width(LINE_WORDS)-1:0]    cache_offset,
  output logic [WAYS-1:0]                     cache_enable,
  output logic                                comp,
  output logic                                write,
  output logic                                tag_src,
  output logic                                data_src,
  output logic [off_width(LINE_WORDS)-1:0]    mem_offset,
  output logic                                mem_wr,
  output logic                                mem_rd,
  output logic                                done,
  output logic                                stall,
  output logic                                hit,
  output logic                                err
);

  localparam int OFF_W = off_width(LINE_WORDS);
  localparam int KW    = OFF_W - 1;
  localparam int CNT_W = clog2(LINE_WORDS + MEM_LAT) + 1;

  state_e                   state_q, state_d;
  logic [WORD_BITS-1:0]     addr_q, addr_d, data_q, data_d;
  logic                     wr_q, wr_d, rr_q, rr_d;
  logic [WAYS-1:0]          victim_q, victim_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [WAYS-1:0]          hv, sel_victim;
  logic                     sel_all_valid, advance, req, bad;
  logic [KW-1:0]            fill_idx;

  assign hv       = cache_hit & cache_valid;
  assign req      = rd_in | wr_in;
  assign bad      = (rd_in & wr_in) | addr_in[0] | ((hv & (hv - WAYS'(1))) != '0);
  assign fill_idx = KW'(cnt_q - CNT_W'(MEM_LAT));

  victim_sel #(.WAYS(WAYS)) u_victim_sel (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (cache_valid),
    .advance_i   (advance),
    .victim_o    (sel_victim),
    .all_valid_o (sel_all_valid)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wr_d         = wr_q;
    victim_d     = victim_q;
    rr_d         = rr_q;
    advance      = 1'b0;
    addr_out     = '0;
    data_out     = '0;
    cache_offset = '0;
    cache_enable = '0;
    comp         = 1'b0;
    write        = 1'b0;
    tag_src      = 1'b0;
    data_src     = 1'b0;
    mem_offset   = '0;
    mem_wr       = 1'b0;
    mem_rd       = 1'b0;
    done         = 1'b0;
    stall        = 1'b0;
    hit          = 1'b0;
    err          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req && bad) begin
          err = 1'b1;
        end else if (req) begin
          comp         = 1'b1;
          write        = wr_in;
          cache_enable = '1;
          addr_out     = addr_in;
          data_out     = data_in;
          cache_offset = addr_in[OFF_W-1:0];
          if (hv != '0) begin
            done = 1'b1;
            hit  = 1'b1;
          end else begin
            stall    = 1'b1;
            addr_d   = addr_in;
            data_d   = data_in;
            wr_d     = wr_in;
            victim_d = sel_victim;
            rr_d     = sel_all_valid;
            if ((sel_victim & cache_valid & cache_dirty) != '0) begin
              state_d = ST_EVICT;
            end else begin
              state_d = ST_FILL;
              advance = sel_all_valid;
            end
          end
        end
      end
      ST_EVICT: begin
        stall        = 1'b1;
        addr_out     = addr_q;
        data_out     = data_q;
        cache_enable = victim_q;
        tag_src      = 1'b1;
        mem_wr       = 1'b1;
        mem_offset   = {cnt_q[KW-1:0], 1'b0};
        cache_offset = {cnt_q[KW-1:0], 1'b0};
        if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
          state_d = ST_FILL;
          advance = rr_q;
        end
      end
      ST_FILL: begin
        // Reads issue for the first LINE_WORDS cycles; data lands MEM_LAT cycles later.
        stall        = 1'b1;
        addr_out     = addr_q;
        data_out     = data_q;
        cache_enable = victim_q;
        if (cnt_q < CNT_W'(LINE_WORDS)) begin
          mem_rd     = 1'b1;
          mem_offset = {cnt_q[KW-1:0], 1'b0};
        end
        if (cnt_q >= CNT_W'(MEM_LAT)) begin
          write        = 1'b1;
          data_src     = 1'b1;
          cache_offset = {fill_idx, 1'b0};
        end
        if (cnt_q == CNT_W'(LINE_WORDS + MEM_LAT - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        comp         = 1'b1;
        write        = wr_q;
        cache_enable = victim_q;
        done         = 1'b1;
        addr_out     = addr_q;
        data_out     = data_q;
        cache_offset = addr_q[OFF_W-1:0];
        state_d      = ST_IDLE;
      end
      default: begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q || state_q == ST_IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      rr_q     <= 1'b0;
      victim_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      rr_q     <= rr_d;
      victim_q <= victim_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb/tb_cache_ctrl_nway.sv - directed self-checking bench for cache_ctrl_nway (4 ways, 4 words, latency 2)
module tb_cache_ctrl_nway;

  localparam int LW = 4;
  localparam int ML = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr_in = '0, data_in = '0;
  logic        rd_in = 1'b0, wr_in = 1'b0;
  logic [3:0]  cache_hit = '0, cache_valid = '0, cache_dirty = '0;
  logic [15:0] addr_out, data_out;
  logic [2:0]  cache_offset, mem_offset;
  logic [3:0]  cache_enable;
  logic        comp, write, tag_src, data_src, mem_wr, mem_rd, done, stall, hit, err;

  // {err, done, hit, stall, comp, write, tag_src, data_src, mem_wr, mem_rd, enable, mem_off, cache_off}
  logic [19:0] obs;
  assign obs = {err, done, hit, stall, comp, write, tag_src, data_src, mem_wr, mem_rd,
                cache_enable, mem_offset, cache_offset};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_ctrl_nway #(.WAYS(4), .LINE_WORDS(LW), .MEM_LAT(ML)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .rd_in        (rd_in),
    .wr_in        (wr_in),
    .cache_hit    (cache_hit),
    .cache_valid  (cache_valid),
    .cache_dirty  (cache_dirty),
    .addr_out     (addr_out),
    .data_out     (data_out),
    .cache_offset (cache_offset),
    .cache_enable (cache_enable),
    .comp         (comp),
    .write        (write),
    .tag_src      (tag_src),
    .data_src     (data_src),
    .mem_offset   (mem_offset),
    .mem_wr       (mem_wr),
    .mem_rd       (mem_rd),
    .done         (done),
    .stall        (stall),
    .hit          (hit),
    .err          (err)
  );

  task automatic test_reset;
    @(negedge clk); #1;
    n_checks++;
    if (obs !== 20'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b", obs, 20'b0);
    end
    @(negedge clk); rst = 1'b0; #1;
    n_checks++;
    if (obs !== 20'b0) begin
      n_fail++;
      $display("FAIL idle_no_request: got %b want %b", obs, 20'b0);
    end
  endtask

  task automatic test_hit;
    @(negedge clk);
    addr_in = 16'h0104; rd_in = 1'b1; cache_hit = 4'b0100; cache_valid = 4'b0100;
    #1;
    n_checks++;
    if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 3'd0, 3'd4}) begin
      n_fail++;
      $display("FAIL read_hit: got %b want %b", obs,
               {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 3'd0, 3'd4});
    end
    @(negedge clk); rd_in = 1'b0; cache_hit = '0; #1;
    n_checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_stays_idle: got stall=%b done=%b want 0 0", stall, done);
    end
  endtask

  // One miss from request to done; ev_words is LW for a dirty victim, 0 for a clean one.
  task automatic test_miss(input string name, input logic [15:0] a, input logic [15:0] d,
                           input logic w, input logic [3:0] v, input logic [3:0] dty,
                           input logic [3:0] vic, input int ev_words);
    int total, c, k;
    logic [19:0] exp;
    total = ev_words + LW + ML + 1;
    for (int cyc = 0; cyc <= total; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        addr_in = a; data_in = d; wr_in = w; rd_in = ~w;
        cache_valid = v; cache_dirty = dty; cache_hit = 4'b0000;
      end else if (cyc == 1) begin
        addr_in = 16'h0A0A; data_in = 16'h5555;
      end
      #1;
      if (cyc == 0) begin
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, w, 4'b0000, 4'b1111, 3'd0, a[2:0]};
      end else if (cyc <= ev_words) begin
        k = cyc - 1;
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, vic, 3'(2 * k), 3'(2 * k)};
      end else if (cyc < total) begin
        c = cyc - 1 - ev_words;
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (c >= ML), 1'b0, (c >= ML), 1'b0, (c < LW), vic,
               (c < LW) ? 3'(2 * c) : 3'd0, (c >= ML) ? 3'(2 * (c - ML)) : 3'd0};
      end else begin
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, w, 4'b0000, vic, 3'd0, a[2:0]};
      end
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b want %b", name, cyc, obs, exp);
      end
      if (cyc == 1) begin
        n_checks++;
        if (addr_out !== a || data_out !== d) begin
          n_fail++;
          $display("FAIL %s latched: got addr=%h data=%h want addr=%h data=%h",
                   name, addr_out, data_out, a, d);
        end
      end
    end
    @(negedge clk); rd_in = 1'b0; wr_in = 1'b0;
  endtask

  task automatic test_errors;
    @(negedge clk);
    addr_in = 16'h0100; rd_in = 1'b1; wr_in = 1'b1; cache_hit = 4'b0001; cache_valid = 4'b0001;
    #1;
    n_checks++;
    if (obs !== {1'b1, 19'b0}) begin
      n_fail++;
      $display("FAIL err_rd_wr: got %b want %b", obs, {1'b1, 19'b0});
    end
    @(negedge clk); wr_in = 1'b0; addr_in = 16'h0103; #1;
    n_checks++;
    if (obs !== {1'b1, 19'b0}) begin
      n_fail++;
      $display("FAIL err_odd_addr: got %b want %b", obs, {1'b1, 19'b0});
    end
    @(negedge clk); addr_in = 16'h0100; cache_hit = 4'b0011; cache_valid = 4'b0011; #1;
    n_checks++;
    if (obs !== {1'b1, 19'b0}) begin
      n_fail++;
      $display("FAIL err_multi_hit: got %b want %b", obs, {1'b1, 19'b0});
    end
    @(negedge clk); rd_in = 1'b0; cache_hit = '0; #1;
    n_checks++;
    if (obs !== 20'b0) begin
      n_fail++;
      $display("FAIL err_stays_idle: got %b want %b", obs, 20'b0);
    end
  endtask

  task automatic test_reset_mid_fill;
    @(negedge clk);
    addr_in = 16'h0500; data_in = 16'h1234; rd_in = 1'b1;
    cache_valid = 4'b0000; cache_dirty = 4'b0000; cache_hit = 4'b0000;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (obs !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 3'd6, 3'd2}) begin
      n_fail++;
      $display("FAIL fill_cycle3: got %b want %b", obs,
               {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 3'd6, 3'd2});
    end
    rst = 1'b1; rd_in = 1'b0; #1;
    n_checks++;
    if (obs !== 20'b0) begin
      n_fail++;
      $display("FAIL reset_mid_fill: got %b want %b", obs, 20'b0);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    addr_in = 16'h0104; rd_in = 1'b1; cache_hit = 4'b0100; cache_valid = 4'b0100; #1;
    n_checks++;
    if (done !== 1'b1 || hit !== 1'b1 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_after_reset: got done=%b hit=%b stall=%b want 1 1 0", done, hit, stall);
    end
    @(negedge clk); rd_in = 1'b0; cache_hit = '0;
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss("clean_write_miss", 16'h0200, 16'hBEEF, 1'b1, 4'b0000, 4'b0000, 4'b0001, 0);
    test_miss("dirty_read_miss", 16'h0306, 16'h0000, 1'b0, 4'b1111, 4'b0001, 4'b0001, LW);
    test_miss("round_robin_miss", 16'h0400, 16'h0000, 1'b0, 4'b1111, 4'b0000, 4'b0010, 0);
    test_miss("first_invalid_miss", 16'h0408, 16'hCAFE, 1'b1, 4'b1011, 4'b1111, 4'b0100, 0);
    test_errors();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
